mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port behavioural `mem` between the instruction-fetch path and a load/store path. It sits between the core's fetch/LSU logic and the `mem_intf` memory signals. Each cycle it grants at most one request and translates the byte address to a word index. It returns the response one cycle later, tagged to the granted requester. Misaligned and out-of-range accesses are rejected locally and never reach memory.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for mem_arbiter and its grant picker.
// MEM_ARB_RR_EN (used in mem_arb_pick) selects round-robin instead of LS priority.
package mem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  localparam int unsigned MAX_BURST_DEF = 4;

  // Word index is computed at a fixed wide width and narrowed by the caller.
  localparam int unsigned IDX_W = 64;

  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_LS = 1;

  function automatic logic [IDX_W-1:0] word_index(input logic [IDX_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for mem_arbiter; one-hot grant (GNT_IF / GNT_LS).
// MEM_ARB_RR_EN defined: round-robin on contention; otherwise LS priority with burst limit.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             if_valid,
  input  logic             ls_valid,
  input  owner_e           last_grant,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic [1:0]       grant
);

  always_comb begin
    grant = '0;
    if (if_valid && ls_valid) begin
`ifdef MEM_ARB_RR_EN
      if (last_grant == OWN_LS) grant[GNT_IF] = 1'b1;
      else                      grant[GNT_LS] = 1'b1;
`else
      if (burst_cnt == CNT_W'(MAX_BURST)) grant[GNT_IF] = 1'b1;
      else                                grant[GNT_LS] = 1'b1;
`endif
    end else if (ls_valid) begin
      grant[GNT_LS] = 1'b1;
    end else if (if_valid) begin
      grant[GNT_IF] = 1'b1;
    end
  end

`ifdef MEM_ARB_RR_EN
  logic unused_burst;
  assign unused_burst = ^burst_cnt;
`else
  logic unused_last;
  assign unused_last = ^last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-port registered memory.
// Arbitration policy chosen by MEM_ARB_RR_EN inside mem_arb_pick.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned BUSWIDTH  = 32,
  parameter int unsigned RAMDEPTH  = 1024,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 cpu_rst,

  input  logic                 if_req_valid,
  input  logic [ADDRWIDTH-1:0] if_req_addr,
  output logic                 if_req_ready,
  output logic                 if_rsp_valid,
  output logic [BUSWIDTH-1:0]  if_rsp_data,
  output logic                 if_rsp_err,

  input  logic                 ls_req_valid,
  input  logic                 ls_req_we,
  input  logic [ADDRWIDTH-1:0] ls_req_addr,
  input  logic [BUSWIDTH-1:0]  ls_req_wdata,
  output logic                 ls_req_ready,
  output logic                 ls_rsp_valid,
  output logic [BUSWIDTH-1:0]  ls_rsp_data,
  output logic                 ls_rsp_err,

  output logic [ADDRWIDTH-1:0] mem_rd_addr,
  output logic [ADDRWIDTH-1:0] mem_wr_addr,
  output logic [BUSWIDTH-1:0]  mem_wr_data,
  output logic                 mem_wren,
  input  logic [BUSWIDTH-1:0]  mem_rd_data
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  owner_e               rsp_owner;
  logic                 rsp_err;
  logic                 rsp_is_store;
  owner_e               last_grant;
  logic [CNT_W-1:0]     burst_cnt;
  logic [CNT_W-1:0]     burst_nxt;
  logic [ADDRWIDTH-1:0] rd_addr_q;

  logic [IDX_W-1:0]     if_idx_w;
  logic [IDX_W-1:0]     ls_idx_w;
  logic [ADDRWIDTH-1:0] if_idx;
  logic [ADDRWIDTH-1:0] ls_idx;
  logic                 if_err;
  logic                 ls_err;

  logic                 if_cand;
  logic                 ls_cand;
  logic [1:0]           grant;
  logic                 grant_if;
  logic                 grant_ls;
  logic                 if_rd_go;
  logic                 ls_rd_go;

  always_comb begin
    if_idx_w = word_index(IDX_W'(if_req_addr));
    ls_idx_w = word_index(IDX_W'(ls_req_addr));
    if_err   = (if_req_addr[1:0] != 2'b00) || (if_idx_w >= IDX_W'(RAMDEPTH));
    ls_err   = (ls_req_addr[1:0] != 2'b00) || (ls_idx_w >= IDX_W'(RAMDEPTH));
    if_idx   = ADDRWIDTH'(if_idx_w);
    ls_idx   = ADDRWIDTH'(ls_idx_w);
  end

  // No grant can be issued while reset is held, so ready reads 0 throughout reset.
  assign if_cand = if_req_valid && !cpu_rst;
  assign ls_cand = ls_req_valid && !cpu_rst;

  mem_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .if_valid   (if_cand),
    .ls_valid   (ls_cand),
    .last_grant (last_grant),
    .burst_cnt  (burst_cnt),
    .grant      (grant)
  );

  assign grant_if     = grant[GNT_IF];
  assign grant_ls     = grant[GNT_LS];
  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  always_comb begin
    if_rd_go    = grant_if && !if_err;
    ls_rd_go    = grant_ls && !ls_req_we && !ls_err;
    mem_wren    = grant_ls && ls_req_we && !ls_err;
    mem_rd_addr = rd_addr_q;
    if (if_rd_go)      mem_rd_addr = if_idx;
    else if (ls_rd_go) mem_rd_addr = ls_idx;
    mem_wr_addr = mem_wren ? ls_idx : '0;
    mem_wr_data = mem_wren ? ls_req_wdata : '0;
  end

  always_comb begin
    burst_nxt = burst_cnt;
    if (!if_req_valid || grant_if) begin
      burst_nxt = '0;
    end else if (grant_ls && (burst_cnt != CNT_W'(MAX_BURST))) begin
      burst_nxt = burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rsp_owner    <= OWN_NONE;
      rsp_err      <= 1'b0;
      rsp_is_store <= 1'b0;
      last_grant   <= OWN_IF;
      burst_cnt    <= '0;
      rd_addr_q    <= '0;
    end else begin
      rd_addr_q    <= mem_rd_addr;
      burst_cnt    <= burst_nxt;
      rsp_is_store <= grant_ls && ls_req_we;
      if (grant_if) begin
        rsp_owner  <= OWN_IF;
        rsp_err    <= if_err;
        last_grant <= OWN_IF;
      end else if (grant_ls) begin
        rsp_owner  <= OWN_LS;
        rsp_err    <= ls_err;
        last_grant <= OWN_LS;
      end else begin
        rsp_owner  <= OWN_NONE;
        rsp_err    <= 1'b0;
      end
    end
  end

  always_comb begin
    if_rsp_valid = (rsp_owner == OWN_IF);
    ls_rsp_valid = (rsp_owner == OWN_LS);
    if_rsp_err   = if_rsp_valid && rsp_err;
    ls_rsp_err   = ls_rsp_valid && rsp_err;
    if_rsp_data  = (if_rsp_valid && !rsp_err) ? mem_rd_data : '0;
    ls_rsp_data  = (ls_rsp_valid && !rsp_err && !rsp_is_store) ? mem_rd_data : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (word-addressed memory, grant-order rules).
module tb_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned BW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned MB    = 4;

  logic          clk = 1'b0;
  logic          cpu_rst;
  logic          if_req_valid;
  logic [AW-1:0] if_req_addr;
  logic          if_req_ready;
  logic          if_rsp_valid;
  logic [BW-1:0] if_rsp_data;
  logic          if_rsp_err;
  logic          ls_req_valid;
  logic          ls_req_we;
  logic [AW-1:0] ls_req_addr;
  logic [BW-1:0] ls_req_wdata;
  logic          ls_req_ready;
  logic          ls_rsp_valid;
  logic [BW-1:0] ls_rsp_data;
  logic          ls_rsp_err;
  logic [AW-1:0] mem_rd_addr;
  logic [AW-1:0] mem_wr_addr;
  logic [BW-1:0] mem_wr_data;
  logic          mem_wren;
  logic [BW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDRWIDTH (AW),
    .BUSWIDTH  (BW),
    .RAMDEPTH  (DEPTH),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .cpu_rst      (cpu_rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .ls_req_valid (ls_req_valid),
    .ls_req_we    (ls_req_we),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_data  (ls_rsp_data),
    .ls_rsp_err   (ls_rsp_err),
    .mem_rd_addr  (mem_rd_addr),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wren     (mem_wren),
    .mem_rd_data  (mem_rd_data)
  );

  function automatic logic [BW-1:0] init_word(input int unsigned i);
    return 32'hA5000000 ^ (i * 32'h00010003);
  endfunction

  // Behavioural single-port memory with registered read.
  logic [BW-1:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    mem_rd_data = tb_mem[mem_rd_addr[9:0]];
    if (mem_wren) tb_mem[mem_wr_addr[9:0]] = mem_wr_data;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  typedef struct {
    int unsigned   cyc;
    logic          err;
    logic [BW-1:0] data;
  } exp_t;

  typedef struct {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } req_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  exp_t mon_e;

  // Reference model state
  logic [BW-1:0] model_mem [int unsigned];
  req_t          pif;
  req_t          pls;
  int unsigned   ls_streak;
  logic          last_if;
  logic [AW-1:0] exp_rd_idx;
  logic          dut_if_ready_s;
  logic          g_if;
  logic          g_ls;

  function automatic logic [BW-1:0] model_read(input logic [AW-1:0] idx);
    if (model_mem.exists(idx)) return model_mem[idx];
    return init_word(idx);
  endfunction

  function automatic logic addr_err(input logic [AW-1:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 11);
    if (r == 0) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
    if (r == 2) return 32'($urandom);
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  // One bus cycle: entered at negedge, drives pending requests, checks the grant
  // and memory port against the model, queues the expected responses.
  task automatic run_cycle(output logic gi, output logic gl);
    exp_t          e;
    logic          exp_wren;
    logic [AW-1:0] exp_wr_addr;
    logic [BW-1:0] exp_wr_data;
    if_req_valid = pif.v;
    if_req_addr  = pif.addr;
    ls_req_valid = pls.v;
    ls_req_we    = pls.we;
    ls_req_addr  = pls.addr;
    ls_req_wdata = pls.wdata;
    #1;
    if (pif.v && pls.v) begin
`ifdef MEM_ARB_RR_EN
      gl = last_if;
      gi = !last_if;
`else
      gi = (ls_streak >= MB);
      gl = !gi;
`endif
    end else begin
      gi = pif.v;
      gl = pls.v;
    end
    dut_if_ready_s = if_req_ready;
    chk("if_req_ready", if_req_ready, gi);
    chk("ls_req_ready", ls_req_ready, gl);
    exp_wren    = 1'b0;
    exp_wr_addr = '0;
    exp_wr_data = '0;
    e.cyc = cyc + 1;
    if (gi) begin
      e.err  = addr_err(pif.addr);
      e.data = e.err ? '0 : model_read(pif.addr / 4);
      if (!e.err) exp_rd_idx = pif.addr / 4;
      if_q.push_back(e);
    end
    if (gl) begin
      e.err  = addr_err(pls.addr);
      e.data = '0;
      if (!e.err && pls.we) begin
        exp_wren    = 1'b1;
        exp_wr_addr = pls.addr / 4;
        exp_wr_data = pls.wdata;
        model_mem[pls.addr / 4] = pls.wdata;
      end else if (!e.err) begin
        e.data     = model_read(pls.addr / 4);
        exp_rd_idx = pls.addr / 4;
      end
      ls_q.push_back(e);
    end
    chk("mem_wren", mem_wren, exp_wren);
    chk("mem_rd_addr", mem_rd_addr, exp_rd_idx);
    if (exp_wren) begin
      chk("mem_wr_addr", mem_wr_addr, exp_wr_addr);
      chk("mem_wr_data", mem_wr_data, exp_wr_data);
    end
    if (!pif.v || gi) ls_streak = 0;
    else if (gl && ls_streak < MB) ls_streak++;
    if (gi) last_if = 1'b1;
    else if (gl) last_if = 1'b0;
    if (gi) pif.v = 1'b0;
    if (gl) pls.v = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) if (pif.v || pls.v) run_cycle(g_if, g_ls);
    repeat (2) run_cycle(g_if, g_ls);
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    if (cpu_rst !== 1'b1) begin
      if (if_rsp_valid) begin
        if (if_q.size() == 0) chk("if_rsp_unexpected", if_rsp_valid, 1'b0);
        else begin
          mon_e = if_q.pop_front();
          chk("if_rsp_cycle", cyc, mon_e.cyc);
          chk("if_rsp_err", if_rsp_err, mon_e.err);
          chk("if_rsp_data", if_rsp_data, mon_e.data);
        end
      end else if (if_q.size() > 0 && if_q[0].cyc <= cyc) begin
        chk("if_rsp_missing", if_rsp_valid, 1'b1);
        mon_e = if_q.pop_front();
      end
      if (ls_rsp_valid) begin
        if (ls_q.size() == 0) chk("ls_rsp_unexpected", ls_rsp_valid, 1'b0);
        else begin
          mon_e = ls_q.pop_front();
          chk("ls_rsp_cycle", cyc, mon_e.cyc);
          chk("ls_rsp_err", ls_rsp_err, mon_e.err);
          chk("ls_rsp_data", ls_rsp_data, mon_e.data);
        end
      end else if (ls_q.size() > 0 && ls_q[0].cyc <= cyc) begin
        chk("ls_rsp_missing", ls_rsp_valid, 1'b1);
        mon_e = ls_q.pop_front();
      end
    end
  end

  logic [AW-1:0] next_if;
  logic          exp_gi;

  initial begin
    cpu_rst      = 1'b1;
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
    ls_req_addr  = '0;
    ls_req_wdata = '0;
    pif          = '{v: 1'b0, we: 1'b0, addr: '0, wdata: '0};
    pls          = '{v: 1'b0, we: 1'b0, addr: '0, wdata: '0};
    ls_streak    = 0;
    last_if      = 1'b1;
    exp_rd_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) tb_mem[i] = init_word(i);
    tb_mem[4]    = 32'hDEADBEEF;
    model_mem[4] = 32'hDEADBEEF;

    // Reset state
    #2;
    chk("rst_if_ready", if_req_ready, 1'b0);
    chk("rst_ls_ready", ls_req_ready, 1'b0);
    chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
    chk("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
    chk("rst_if_rsp_data", if_rsp_data, '0);
    chk("rst_ls_rsp_data", ls_rsp_data, '0);
    chk("rst_if_rsp_err", if_rsp_err, 1'b0);
    chk("rst_ls_rsp_err", ls_rsp_err, 1'b0);
    chk("rst_mem_wren", mem_wren, 1'b0);
    chk("rst_mem_rd_addr", mem_rd_addr, '0);
    chk("rst_mem_wr_addr", mem_wr_addr, '0);
    chk("rst_mem_wr_data", mem_wr_data, '0);
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h8;
    #1;
    chk("rst_if_ready_held", if_req_ready, 1'b0);
    chk("rst_ls_ready_held", ls_req_ready, 1'b0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    cpu_rst = 1'b0;

    // Contention straight out of reset
    next_if = '0;
    for (int k = 0; k < 10; k++) begin
      if (!pif.v) begin
        pif = '{v: 1'b1, we: 1'b0, addr: next_if, wdata: '0};
        next_if += 4;
      end
      if (!pls.v) pls = '{v: 1'b1, we: 1'b0, addr: 32'h100 + 32'(k * 4), wdata: '0};
      run_cycle(g_if, g_ls);
`ifdef MEM_ARB_RR_EN
      exp_gi = (k % 2 == 1);
`else
      exp_gi = (k % 5 == 4);
`endif
      chk("contention_order", dut_if_ready_s, exp_gi);
    end
    drain();

    // Solo fetch of mem[4]
    pif = '{v: 1'b1, we: 1'b0, addr: 32'h10, wdata: '0};
    run_cycle(g_if, g_ls);
    drain();

    // Store then load of the same word
    pls = '{v: 1'b1, we: 1'b1, addr: 32'h20, wdata: 32'h12345678};
    run_cycle(g_if, g_ls);
    pls = '{v: 1'b1, we: 1'b0, addr: 32'h20, wdata: '0};
    run_cycle(g_if, g_ls);
    drain();

    // Misaligned fetch, out-of-range store
    pif = '{v: 1'b1, we: 1'b0, addr: 32'h6, wdata: '0};
    run_cycle(g_if, g_ls);
    pls = '{v: 1'b1, we: 1'b1, addr: 32'h1000, wdata: 32'hCAFEF00D};
    run_cycle(g_if, g_ls);
    drain();

    // Back-to-back fetches
    for (int k = 0; k < 3; k++) begin
      pif = '{v: 1'b1, we: 1'b0, addr: 32'(k * 4), wdata: '0};
      run_cycle(g_if, g_ls);
    end
    drain();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if (!pif.v && $urandom_range(0, 3) != 0)
        pif = '{v: 1'b1, we: 1'b0, addr: rand_addr(), wdata: '0};
      if (!pls.v && $urandom_range(0, 2) != 0)
        pls = '{v: 1'b1, we: 1'($urandom_range(0, 1)), addr: rand_addr(), wdata: 32'($urandom)};
      run_cycle(g_if, g_ls);
    end
    drain();

    // Reset in the response cycle of an LS load
    if_req_valid = 1'b0;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    ls_req_addr  = 32'h40;
    #1;
    chk("rstop_ls_ready", ls_req_ready, 1'b1);
    chk("rstop_mem_rd_addr", mem_rd_addr, 32'h10);
    @(posedge clk);
    #2 cpu_rst = 1'b1;
    #1;
    chk("rstop_ls_rsp_valid", ls_rsp_valid, 1'b0);
    chk("rstop_ls_ready_in_rst", ls_req_ready, 1'b0);
    chk("rstop_mem_rd_addr_rst", mem_rd_addr, '0);
    ls_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    cpu_rst    = 1'b0;
    ls_streak  = 0;
    last_if    = 1'b1;
    exp_rd_idx = '0;
    for (int k = 0; k < 3; k++) begin
      run_cycle(g_if, g_ls);
      chk("rstop_ls_rsp_after", ls_rsp_valid, 1'b0);
    end

    // Traffic still flows after the reset
    pls = '{v: 1'b1, we: 1'b0, addr: 32'h20, wdata: '0};
    run_cycle(g_if, g_ls);
    drain();

    chk("if_q_drained", 64'(if_q.size()), 64'd0);
    chk("ls_q_drained", 64'(ls_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
